// File: rtl/amba3_axi_mem_slave_if.sv
// amba3_axi_mem_slave_if: AXI3 address/data/response channel bundle with master and slave views
interface amba3_axi_mem_slave_if #(
  parameter int TXID_SIZE = 4,
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 128
);
  logic [TXID_SIZE-1:0]   awid;
  logic [ADDR_SIZE-1:0]   awaddr;
  logic [3:0]             awlen;
  logic [1:0]             awburst;
  logic                   awvalid;
  logic                   awready;
  logic [DATA_SIZE-1:0]   wdata;
  logic [DATA_SIZE/8-1:0] wstrb;
  logic                   wlast;
  logic                   wvalid;
  logic                   wready;
  logic [TXID_SIZE-1:0]   bid;
  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready;
  logic [TXID_SIZE-1:0]   arid;
  logic [ADDR_SIZE-1:0]   araddr;
  logic [3:0]             arlen;
  logic [1:0]             arburst;
  logic                   arvalid;
  logic                   arready;
  logic [TXID_SIZE-1:0]   rid;
  logic [DATA_SIZE-1:0]   rdata;
  logic [1:0]             rresp;
  logic                   rlast;
  logic                   rvalid;
  logic                   rready;
  modport slave (
    input  awid, awaddr, awlen, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arburst, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
  modport master (
    output awid, awaddr, awlen, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arburst, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/amba3_axi_mem_slave.sv
// amba3_axi_mem_slave: AXI3 memory slave with independent write and read burst FSMs over a word-wide RAM
module amba3_axi_mem_slave #(
  parameter int TXID_SIZE = 4,
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 128,
  parameter int MEM_DEPTH = 256
) (
  input logic aclk,
  input logic areset,
  amba3_axi_mem_slave_if.slave s
);
  localparam int OFS = $clog2(DATA_SIZE / 8);
  localparam int IW  = $clog2(MEM_DEPTH);
  localparam int NB  = DATA_SIZE / 8;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;
  logic [DATA_SIZE-1:0] r_mem [MEM_DEPTH];
  w_state_t             r_wstate, w_wnext;
  logic [TXID_SIZE-1:0] r_wid;
  logic [IW-1:0]        r_widx;
  logic [3:0]           r_wlen, r_wcnt;
  logic                 r_wfix, r_werr;
  logic                 w_aw_hs, w_w_hs, w_wfinal;
  r_state_t             r_rstate, w_rnext;
  logic [TXID_SIZE-1:0] r_rid;
  logic [IW-1:0]        r_ridx;
  logic [3:0]           r_rlen, r_rcnt;
  logic                 r_rfix, r_rerr, r_rlast;
  logic [1:0]           r_rresp;
  logic [DATA_SIZE-1:0] r_rdata;
  logic                 w_ar_hs, w_r_hs;
  logic                 w_unused;
  // Address bits outside the word index are deliberately ignored
  assign w_unused = ^{s.awaddr, s.araddr};
  assign w_aw_hs  = (r_wstate == W_IDLE) && s.awvalid;
  assign w_w_hs   = (r_wstate == W_DATA) && s.wvalid;
  assign w_wfinal = r_wcnt == r_wlen;
  always_ff @(posedge aclk) r_wstate <= areset ? W_IDLE : w_wnext;
  always_comb begin
    w_wnext = r_wstate;
    w_wnext = w_aw_hs                            ? W_DATA :
              (w_w_hs && w_wfinal)               ? W_RESP :
              (r_wstate == W_RESP && s.bready)   ? W_IDLE : r_wstate;
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wid  <= '0;
      r_widx <= '0;
      r_wlen <= '0;
      r_wcnt <= '0;
      r_wfix <= 1'b0;
      r_werr <= 1'b0;
    end else if (w_aw_hs) begin
      r_wid  <= s.awid;
      r_widx <= s.awaddr[OFS +: IW];
      r_wlen <= s.awlen;
      r_wcnt <= '0;
      r_wfix <= s.awburst == 2'b00;
      r_werr <= s.awburst[1];
    end else if (w_w_hs) begin
      r_widx <= r_wfix ? r_widx : r_widx + 1'b1;
      r_wcnt <= r_wcnt + 1'b1;
      if (s.wlast != w_wfinal) r_werr <= 1'b1;
    end
  end
  always_ff @(posedge aclk) begin
    if (w_w_hs && !areset)
      for (int i = 0; i < NB; i++)
        if (s.wstrb[i]) r_mem[r_widx][i*8 +: 8] <= s.wdata[i*8 +: 8];
  end
  assign s.awready = r_wstate == W_IDLE;
  assign s.wready  = r_wstate == W_DATA;
  assign s.bvalid  = r_wstate == W_RESP;
  assign s.bid     = r_wid;
  assign s.bresp   = (s.bvalid && r_werr) ? 2'b10 : 2'b00;
  assign w_ar_hs = (r_rstate == R_IDLE) && s.arvalid;
  assign w_r_hs  = (r_rstate == R_DATA) && s.rready;
  always_ff @(posedge aclk) r_rstate <= areset ? R_IDLE : w_rnext;
  always_comb begin
    w_rnext = r_rstate;
    w_rnext = w_ar_hs                 ? R_FETCH :
              (r_rstate == R_FETCH)   ? R_DATA  :
              w_r_hs                  ? (r_rlast ? R_IDLE : R_FETCH) : r_rstate;
  end
  // Fetch reads the array before any same-edge write lands, so a colliding write returns old data
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_rid   <= '0;
      r_ridx  <= '0;
      r_rlen  <= '0;
      r_rcnt  <= '0;
      r_rfix  <= 1'b0;
      r_rerr  <= 1'b0;
      r_rdata <= '0;
      r_rlast <= 1'b0;
      r_rresp <= 2'b00;
    end else if (w_ar_hs) begin
      r_rid  <= s.arid;
      r_ridx <= s.araddr[OFS +: IW];
      r_rlen <= s.arlen;
      r_rcnt <= '0;
      r_rfix <= s.arburst == 2'b00;
      r_rerr <= s.arburst[1];
    end else if (r_rstate == R_FETCH) begin
      r_rdata <= r_mem[r_ridx];
      r_rlast <= r_rcnt == r_rlen;
      r_rresp <= r_rerr ? 2'b10 : 2'b00;
    end else if (w_r_hs && !r_rlast) begin
      r_ridx <= r_rfix ? r_ridx : r_ridx + 1'b1;
      r_rcnt <= r_rcnt + 1'b1;
    end
  end
  assign s.arready = r_rstate == R_IDLE;
  assign s.rvalid  = r_rstate == R_DATA;
  assign s.rid     = r_rid;
  assign s.rdata   = r_rdata;
  assign s.rresp   = r_rresp;
  assign s.rlast   = r_rlast;
endmodule
